map_controller: RTL

- Sequencer for the list-map datapath. It walks a source list from the tail down to the head and pushes each element onto an internal continuation stack (call phase).
- It then pops the stack and sends each element through an external function unit over a valid/ready handshake. Each result is written to the result list in ascending order (cont phase).
- It replaces the free-running per-signal handshakes with one FSM that owns the stack pointer and the list pointers.

---
 rtl/map_controller.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/map_controller.sv
// List-map sequencer: pushes a source list onto a continuation stack tail-first, then pops each
// element through an external function unit and writes results in ascending order.
// Optional MAP_CTRL_HWM_EN adds a stack high-water-mark output.
module map_controller #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W:0]       len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_W:0]       result_len,
  output logic                  lr_en,
  output logic [ADDR_W-1:0]     lr_addr,
  input  logic [DATA_W-1:0]     lr_data,
  output logic                  fn_valid,
  input  logic                  fn_ready,
  output logic [DATA_W-1:0]     fn_arg,
  input  logic                  fn_res_valid,
  output logic                  fn_res_ready,
  input  logic [DATA_W-1:0]     fn_res,
  output logic                  rw_en,
  output logic [ADDR_W-1:0]     rw_addr,
  output logic [DATA_W-1:0]     rw_data
`ifdef MAP_CTRL_HWM_EN
  ,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_hwm
`endif
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_PUSH, S_POP, S_FN_REQ, S_FN_WAIT, S_WR, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [SP_W-1:0]     sp_q, sp_d;
  logic [ADDR_W-1:0]   lp_q, lp_d;
  logic [LEN_W-1:0]    wp_q, wp_d;
  logic [DATA_W-1:0]   arg_q, arg_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [LEN_W-1:0]    rlen_q, rlen_d;
  logic                err_q, err_d;
  logic                lr_en_q, fn_valid_q, fn_res_ready_q, rw_en_q, busy_q, done_q;
  logic                push_c;
  logic [DATA_W-1:0]   stack_q [STACK_DEPTH];

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    lp_d    = lp_q;
    wp_d    = wp_q;
    arg_d   = arg_q;
    res_d   = res_q;
    rlen_d  = rlen_q;
    err_d   = err_q;
    push_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sp_d   = '0;
          wp_d   = '0;
          rlen_d = '0;
          err_d  = 1'b0;
          if (len == '0) begin
            state_d = S_DONE;
          end else if (32'(len) > STACK_DEPTH) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            lp_d    = ADDR_W'(len - LEN_W'(1));
            state_d = S_RD_REQ;
          end
        end
      end
      S_RD_REQ: state_d = S_RD_PUSH;
      S_RD_PUSH: begin
        push_c = 1'b1;
        sp_d   = sp_q + SP_W'(1);
        if (lp_q == '0) begin
          state_d = S_POP;
        end else begin
          lp_d    = lp_q - ADDR_W'(1);
          state_d = S_RD_REQ;
        end
      end
      S_POP: begin
        if (sp_q == '0) begin
          rlen_d  = wp_q;
          state_d = S_DONE;
        end else begin
          arg_d   = stack_q[IDX_W'(sp_q - SP_W'(1))];
          sp_d    = sp_q - SP_W'(1);
          state_d = S_FN_REQ;
        end
      end
      S_FN_REQ: begin
        if (fn_valid_q && fn_ready) state_d = S_FN_WAIT;
      end
      S_FN_WAIT: begin
        if (fn_res_valid) begin
          res_d   = fn_res;
          state_d = S_WR;
        end
      end
      S_WR: begin
        wp_d    = wp_q + LEN_W'(1);
        state_d = S_POP;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they are registered yet aligned with their state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      sp_q           <= '0;
      lp_q           <= '0;
      wp_q           <= '0;
      arg_q          <= '0;
      res_q          <= '0;
      rlen_q         <= '0;
      err_q          <= 1'b0;
      lr_en_q        <= 1'b0;
      fn_valid_q     <= 1'b0;
      fn_res_ready_q <= 1'b0;
      rw_en_q        <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      sp_q           <= sp_d;
      lp_q           <= lp_d;
      wp_q           <= wp_d;
      arg_q          <= arg_d;
      res_q          <= res_d;
      rlen_q         <= rlen_d;
      err_q          <= err_d;
      lr_en_q        <= (state_d == S_RD_REQ);
      fn_valid_q     <= (state_d == S_FN_REQ);
      fn_res_ready_q <= (state_d == S_FN_WAIT);
      rw_en_q        <= (state_d == S_WR);
      busy_q         <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q         <= (state_d == S_DONE);
    end
  end

  // Continuation stack storage; contents need no reset
  always_ff @(posedge clk) begin
    if (push_c) stack_q[IDX_W'(sp_q)] <= lr_data;
  end

`ifdef MAP_CTRL_HWM_EN
  logic [SP_W-1:0] hwm_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hwm_q <= '0;
    end else if (push_c && (sp_d > hwm_q)) begin
      hwm_q <= sp_d;
    end
  end

  assign stack_hwm = hwm_q;
`endif

  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign result_len   = rlen_q;
  assign lr_en        = lr_en_q;
  assign lr_addr      = lp_q;
  assign fn_valid     = fn_valid_q;
  assign fn_arg       = arg_q;
  assign fn_res_ready = fn_res_ready_q;
  assign rw_en        = rw_en_q;
  assign rw_addr      = ADDR_W'(wp_q);
  assign rw_data      = res_q;

endmodule
